// File: rtl/hls_deadlock_param_monitor_if.sv
// Status and result bundle between one dataflow region and its deadlock monitor.
// The region side is the master; the monitor is the slave.
interface hls_deadlock_param_monitor_if #(
    parameter int NUM_PROC = 9,
    parameter int NUM_AXIS = 12,
    parameter int EVT_W    = 8
);
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_PROC-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic [NUM_PROC-1:0] sub_block;
    logic                clear;
    logic                block;
    logic                block_confirmed;
    logic                block_sticky;
    logic                deadlock_irq;
    logic [NUM_PROC-1:0] stuck_vec;
    logic [EVT_W-1:0]    event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block, clear,
        input  block, block_confirmed, block_sticky, deadlock_irq, stuck_vec, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block, clear,
        output block, block_confirmed, block_sticky, deadlock_irq, stuck_vec, event_count
    );
endinterface

// File: rtl/hls_deadlock_param_monitor.sv
// Debounced deadlock monitor for one HLS dataflow region: instantaneous flag,
// persistence-filtered confirm, sticky flag, culprit snapshot, event count and irq.
module hls_deadlock_param_monitor #(
    parameter int                            NUM_PROC       = 9,
    parameter int                            NUM_AXIS       = 12,
    parameter logic [NUM_PROC*NUM_AXIS-1:0]  AXIS_MAP       = '0,
    parameter logic [NUM_PROC-1:0]           SUB_MASK       = '0,
    parameter int                            CONFIRM_CYCLES = 16,
    parameter int                            EVT_W          = 8
) (
    input logic                         clock,
    input logic                         reset,
    hls_deadlock_param_monitor_if.slave mon
);
    localparam int               CNT_W    = $clog2(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUSPECT, S_DEADLOCK} state_t;

    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (&v) ? v : v + EVT_W'(1);
    endfunction

    logic [NUM_PROC-1:0] axis_hit;
    logic [NUM_PROC-1:0] pab;
    logic [NUM_PROC-1:0] stop;
    logic                cond;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                enter;
    logic                confirmed;

    logic                block_p1;
    logic                irq_p1;
    logic                sticky_p1;
    logic [NUM_PROC-1:0] stuck_p1;
    logic [EVT_W-1:0]    count_p1;

    // Stage 0: per-process stop terms; child regions only count as axis-blocked
    // when their own monitor agrees.
    always_comb begin
        axis_hit = '0;
        pab      = '0;
        stop     = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            axis_hit[i] = |(mon.axis_block_sigs & AXIS_MAP[i*NUM_AXIS +: NUM_AXIS]);
            pab[i]      = axis_hit[i] & (SUB_MASK[i] ? mon.sub_block[i] : 1'b1);
            stop[i]     = mon.inst_idle_sigs[i] | mon.inst_block_sigs[i] | pab[i];
        end
    end

    assign cond = (|pab) & (&stop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        enter     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = cond ? CNT_W'(1) : '0;
                if (cond) state_nxt = S_SUSPECT;
            end
            S_SUSPECT: begin
                if (!cond) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_DEADLOCK;
                    enter     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DEADLOCK: begin
                if (!cond) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        confirmed = (state == S_DEADLOCK);
    end

    // Stage 1: registered results; clear is ordered before the entry update so
    // an event on the clearing edge still lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_p1  <= 1'b0;
            irq_p1    <= 1'b0;
            sticky_p1 <= 1'b0;
            stuck_p1  <= '0;
            count_p1  <= '0;
        end else begin
            block_p1 <= cond;
            irq_p1   <= enter;
            if (mon.clear) begin
                sticky_p1 <= 1'b0;
                stuck_p1  <= '0;
                count_p1  <= '0;
            end
            if (enter) begin
                sticky_p1 <= 1'b1;
                stuck_p1  <= pab;
                count_p1  <= sat_inc(mon.clear ? '0 : count_p1);
            end
        end
    end

    assign mon.block           = block_p1;
    assign mon.block_confirmed = confirmed;
    assign mon.block_sticky    = sticky_p1;
    assign mon.deadlock_irq    = irq_p1;
    assign mon.stuck_vec       = stuck_p1;
    assign mon.event_count     = count_p1;
endmodule

// File: doc/hls_deadlock_param_monitor.md
Name: hls_deadlock_param_monitor

Overview:
- Parametrised, debounced deadlock monitor for one HLS dataflow region with NUM_PROC processes and NUM_AXIS AXI-stream block signals.
- Flags a deadlock only when every process is stopped (idle, channel-blocked or axis-blocked) and at least one is axis-blocked.
- Keeps the legacy instantaneous flag. Adds a persistence filter, a sticky flag, an event counter, a per-process culprit snapshot and an interrupt pulse.
- Instantiated once per dataflow region. Child-region monitors feed `sub_block`.

Parameters:
- NUM_PROC, 9, number of dataflow processes (1..64).
- NUM_AXIS, 12, number of axis block signals (1..64).
- AXIS_MAP, all zeros, NUM_PROC*NUM_AXIS-bit mask. Bit [i*NUM_AXIS+j] set means axis signal j belongs to process i.
- SUB_MASK, all zeros, NUM_PROC-bit mask. Bit i set means process i is a child region whose axis block is gated by `sub_block[i]`.
- CONFIRM_CYCLES, 16, consecutive stop cycles required to confirm a deadlock (2..65535).
- EVT_W, 8, width of the saturating event counter.

Ports:
- clock, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, asynchronous active-low reset.
- axis_block_sigs, in, NUM_AXIS, per-stream blocked indication.
- inst_idle_sigs, in, NUM_PROC, per-process idle.
- inst_block_sigs, in, NUM_PROC, per-process channel (FIFO/PIPO) blocked.
- sub_block, in, NUM_PROC, block output of child monitors; ignored where SUB_MASK=0.
- clear, in, 1, synchronous clear of the sticky, count and snapshot state.
- block, out, 1, legacy instantaneous flag, registered.
- block_confirmed, out, 1, high while the FSM is in DEADLOCK.
- block_sticky, out, 1, set on confirm, held until `clear`.
- deadlock_irq, out, 1, one-cycle pulse on DEADLOCK entry.
- stuck_vec, out, NUM_PROC, process_axis_block vector captured at the last confirm.
- event_count, out, EVT_W, number of confirms, saturating.

Behaviour:
- Per-process terms (combinational):
  - axis_hit[i] = |(axis_block_sigs & AXIS_MAP row i).
  - pab[i] = axis_hit[i] & (SUB_MASK[i] ? sub_block[i] : 1).
  - stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | pab[i].
  - cond = (|pab) & (&stop).
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - FSM is in IDLE.
  - Run counter is 0.
- Legacy output: block <= cond every cycle, i.e. 1-cycle latency.
- FSM, run counter width clog2(CONFIRM_CYCLES):
  - IDLE: cond=1 -> SUSPECT, cnt<=1. Otherwise stay, cnt<=0.
  - SUSPECT: cond=0 -> IDLE, cnt<=0. If cond=1 and cnt==CONFIRM_CYCLES-1 -> DEADLOCK. If cond=1 otherwise, cnt<=cnt+1.
  - DEADLOCK: cond=0 -> IDLE, cnt<=0. Otherwise stay.
- Confirm latency:
  - block_confirmed rises on the edge that ends the CONFIRM_CYCLES-th consecutive cond=1 cycle.
  - It falls on the edge after the first cond=0 cycle.
- On the DEADLOCK-entry edge:
  - deadlock_irq<=1 for exactly one cycle.
  - block_sticky<=1.
  - stuck_vec<=pab of that cycle.
  - event_count<=event_count+1, saturating at 2^EVT_W-1.
- Re-entry: each new IDLE->...->DEADLOCK entry re-triggers irq, count and snapshot. Staying in DEADLOCK never re-triggers them.
- clear=1:
  - block_sticky, stuck_vec and event_count are zeroed.
  - FSM, block and block_confirmed are unaffected.
- clear on the entry edge: the clear applies first, then the entry update. Result is sticky=1, count=1, stuck_vec=new snapshot. No event is lost.
- A glitch of cond=0 for a single cycle restarts the count from zero. No hysteresis.
- Reset mid-SUSPECT or mid-DEADLOCK: immediate return to the reset state, no irq.

Test Plan:
- Setup for all cases: NUM_PROC=3, NUM_AXIS=4, AXIS_MAP row0=0001, row1=0110, row2=1000, SUB_MASK=010, CONFIRM_CYCLES=4, EVT_W=2.
- Basic confirm:
  - Stimulus: idle=101, axis=0010, sub_block=010 held for 6 cycles.
  - Response: block=1 from cycle 1. Confirmed and irq high from cycle 4, irq 1 cycle only. stuck_vec=010, event_count=1, sticky=1.
- Glitch:
  - Stimulus: the same stimulus for 3 cycles, then idle=001 for 1 cycle, then the original for 3 cycles.
  - Response: block pulses; confirmed stays 0; count stays 0.
- Sub gate and no-axis cases:
  - Stimulus: axis=0010 with sub_block=000. Response: pab=000, cond=0, block=0.
  - Stimulus: all processes idle, axis=0. Response: block=0.
- Saturation and clear:
  - Stimulus: 4 separate confirm episodes, each separated by cond=0.
  - Response: event_count=3, saturated. Then clear=1 gives count=0, sticky=0, stuck_vec=000, with confirmed unchanged.
- Clear coincident with entry:
  - Response: after the edge, count=1, sticky=1, irq=1.
- Async reset:
  - Stimulus: reset low during DEADLOCK, between clock edges.
  - Response: all outputs 0 immediately, before the next edge. After release, 4 more cond cycles are needed to confirm.
